lms_core: RTL and testbench

Adaptive LMS FIR engine that consumes the sample stream from the input sample reader, together with a desired-signal sample, and produces a filter output and error per sample. One multiplier is time-shared across taps: a state machine runs a filter (MAC) pass and then a weight-update pass per accepted sample. Results feed the downstream error/output logging stage.

---
 rtl/lms_core_if.sv | 27 ++
 rtl/lms_core.sv | 177 +++++++++++++++++
 tb/tb_lms_core.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lms_core_if.sv
// lms_core_if: sample/result bus of the LMS engine.
// Carries the sample input handshake (x_in, d_in, in_valid, in_ready, adapt_en)
// and the registered result side (y_out, e_out, out_valid).
// master: sample source / result consumer.
// slave: the lms_core engine.
interface lms_core_if #(
  parameter int WIDTH = 8
);
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] d_in;
  logic                    in_valid;
  logic                    in_ready;
  logic                    adapt_en;
  logic signed [WIDTH-1:0] y_out;
  logic signed [WIDTH-1:0] e_out;
  logic                    out_valid;

  modport master (
    output x_in, d_in, in_valid, adapt_en,
    input  in_ready, y_out, e_out, out_valid
  );

  modport slave (
    input  x_in, d_in, in_valid, adapt_en,
    output in_ready, y_out, e_out, out_valid
  );
endinterface

// File: rtl/lms_core.sv
// lms_core: adaptive LMS FIR engine with a single time-shared multiplier.
// Each accepted sample runs a FILTER pass (TAPS MAC cycles), one ERROR cycle
// that registers y/e, then an UPDATE pass (TAPS weight-update cycles).
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - lms_core_if.slave: x_in, d_in, in_valid, adapt_en in;
//          in_ready, y_out, e_out, out_valid out
// Optional feature macro: LMS_LEAK_EN (leaky LMS, w -= w >>> LEAK_SHIFT each
// update, applied even when adaptation is disabled).
module lms_core #(
  parameter int TAPS       = 4,
  parameter int WIDTH      = 8,
  parameter int COEF_W     = 16,
  parameter int FRAC       = 8,
  parameter int MU_SHIFT   = 4,
  parameter int LEAK_SHIFT = 8
) (
  input logic        clk,
  input logic        rst,
  lms_core_if.slave  bus
);

  localparam int ACC_W  = WIDTH + COEF_W + $clog2(TAPS) + 1;
  localparam int PROD_W = COEF_W + WIDTH;
  localparam int UPD_W  = PROD_W + 2;
  localparam int K_W    = $clog2(TAPS);
  localparam logic [K_W-1:0] K_LAST = K_W'(TAPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILTER,
    ERROR,
    UPDATE
  } state_t;

  state_t                    state;
  state_t                    next_state;
  logic [K_W-1:0]            k;
  logic signed [ACC_W-1:0]   acc;
  logic signed [WIDTH-1:0]   x_dl [TAPS];
  logic signed [COEF_W-1:0]  w    [TAPS];
  logic signed [WIDTH-1:0]   d_lat;
  logic                      adapt_lat;

  logic signed [COEF_W-1:0]  mul_a;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc_shift;
  logic signed [WIDTH-1:0]   y_sat;
  logic signed [WIDTH:0]     e_full;
  logic signed [WIDTH-1:0]   e_sat;
  logic signed [PROD_W-1:0]  delta;
  logic signed [PROD_W-1:0]  delta_g;
  logic signed [UPD_W-1:0]   w_sum;
  logic signed [COEF_W-1:0]  w_sat;
`ifdef LMS_LEAK_EN
  logic signed [COEF_W-1:0]  leak;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; in_ready is purely a function of being idle.
  always_comb begin
    next_state   = state;
    bus.in_ready = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) next_state = FILTER;
      end
      FILTER:  if (k == K_LAST) next_state = ERROR;
      ERROR:   next_state = UPDATE;
      UPDATE:  if (k == K_LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Shared multiplier: w[k]*x[k] while filtering, e*x[k] while updating.
  // e is sign-extended to the weight width so one COEF_W x WIDTH product serves both.
  always_comb begin
    mul_a = w[k];
    if (state == UPDATE) mul_a = COEF_W'(bus.e_out);
    prod = PROD_W'(mul_a) * PROD_W'(x_dl[k]);
  end

  // Output and error saturation. A value fits the narrower width when all
  // bits above its sign bit match the sign.
  always_comb begin
    acc_shift = acc >>> FRAC;
    if (acc_shift[ACC_W-1:WIDTH-1] == {(ACC_W-WIDTH+1){acc_shift[ACC_W-1]}})
      y_sat = acc_shift[WIDTH-1:0];
    else if (acc_shift[ACC_W-1])
      y_sat = {1'b1, {(WIDTH-1){1'b0}}};
    else
      y_sat = {1'b0, {(WIDTH-1){1'b1}}};

    e_full = (WIDTH+1)'(d_lat) - (WIDTH+1)'(y_sat);
    if (e_full[WIDTH] == e_full[WIDTH-1])
      e_sat = e_full[WIDTH-1:0];
    else if (e_full[WIDTH])
      e_sat = {1'b1, {(WIDTH-1){1'b0}}};
    else
      e_sat = {1'b0, {(WIDTH-1){1'b1}}};
  end

  // Weight update for tap k; delta is zeroed when adaptation was off at accept.
  always_comb begin
    delta   = prod >>> MU_SHIFT;
    delta_g = '0;
    if (adapt_lat) delta_g = delta;
`ifdef LMS_LEAK_EN
    leak  = w[k] >>> LEAK_SHIFT;
    w_sum = UPD_W'(w[k]) - UPD_W'(leak) + UPD_W'(delta_g);
`else
    w_sum = UPD_W'(w[k]) + UPD_W'(delta_g);
`endif
    if (w_sum[UPD_W-1:COEF_W-1] == {(UPD_W-COEF_W+1){w_sum[UPD_W-1]}})
      w_sat = w_sum[COEF_W-1:0];
    else if (w_sum[UPD_W-1])
      w_sat = {1'b1, {(COEF_W-1){1'b0}}};
    else
      w_sat = {1'b0, {(COEF_W-1){1'b1}}};
  end

  // Datapath: delay line, latches, accumulator, weights and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k             <= '0;
      acc           <= '0;
      d_lat         <= '0;
      adapt_lat     <= 1'b0;
      bus.y_out     <= '0;
      bus.e_out     <= '0;
      bus.out_valid <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_dl[i] <= '0;
        w[i]    <= '0;
      end
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_dl[0] <= bus.x_in;
            for (int i = 1; i < TAPS; i++) x_dl[i] <= x_dl[i-1];
            d_lat     <= bus.d_in;
            adapt_lat <= bus.adapt_en;
            acc       <= '0;
            k         <= '0;
          end
        end
        FILTER: begin
          acc <= acc + ACC_W'(prod);
          k   <= (k == K_LAST) ? '0 : k + 1'b1;
        end
        ERROR: begin
          bus.y_out     <= y_sat;
          bus.e_out     <= e_sat;
          bus.out_valid <= 1'b1;
        end
        UPDATE: begin
          w[k] <= w_sat;
          k    <= (k == K_LAST) ? '0 : k + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lms_core.sv
// tb_lms_core: self-checking bench for lms_core.
// A behavioural LMS model (integer arithmetic, floor division, clamping)
// predicts in_ready/out_valid/y/e every cycle; directed vectors add
// hand-computed literal expectations. Honors LMS_LEAK_EN like the design.
module tb_lms_core;

  localparam int TAPS       = 4;
  localparam int WIDTH      = 8;
  localparam int COEF_W     = 16;
  localparam int FRAC       = 8;
  localparam int MU_SHIFT   = 4;
  localparam int LEAK_SHIFT = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  lms_core_if #(.WIDTH(WIDTH)) bus ();

  lms_core #(
    .TAPS(TAPS), .WIDTH(WIDTH), .COEF_W(COEF_W), .FRAC(FRAC),
    .MU_SHIFT(MU_SHIFT), .LEAK_SHIFT(LEAK_SHIFT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Behavioural model: the whole sample is computed at accept; results become
  // visible TAPS+1 edges later and the engine is busy for 2*TAPS+1 edges.
  longint mw [TAPS];
  longint mx [TAPS];
  bit     m_active = 1'b0;
  int     m_since  = 0;
  longint m_pend_y = 0;
  longint m_pend_e = 0;
  longint m_y      = 0;
  longint m_e      = 0;
  bit     m_ov     = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_since  = 0;
      m_y      = 0;
      m_e      = 0;
      m_ov     = 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        mw[i] = 0;
        mx[i] = 0;
      end
    end else begin
      m_ov = 1'b0;
      if (m_active) begin
        m_since++;
        if (m_since == TAPS + 1) begin
          m_y  = m_pend_y;
          m_e  = m_pend_e;
          m_ov = 1'b1;
        end
        if (m_since == 2 * TAPS + 1) m_active = 1'b0;
      end else if (bus.in_valid) begin
        longint acc;
        longint dl;
        for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = longint'($signed(bus.x_in));
        acc = 0;
        for (int i = 0; i < TAPS; i++) acc += mw[i] * mx[i];
        m_pend_y = clamp(floor_div(acc, longint'(1) << FRAC), WIDTH);
        m_pend_e = clamp(longint'($signed(bus.d_in)) - m_pend_y, WIDTH);
        for (int i = 0; i < TAPS; i++) begin
          dl = bus.adapt_en ? floor_div(m_pend_e * mx[i], longint'(1) << MU_SHIFT) : 0;
`ifdef LMS_LEAK_EN
          mw[i] = clamp(mw[i] - floor_div(mw[i], longint'(1) << LEAK_SHIFT) + dl, COEF_W);
`else
          mw[i] = clamp(mw[i] + dl, COEF_W);
`endif
        end
        m_active = 1'b1;
        m_since  = 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("model_in_ready", longint'(bus.in_ready), longint'(!m_active));
    check("model_out_valid", longint'(bus.out_valid), longint'(m_ov));
    check("model_y_out", longint'($signed(bus.y_out)), m_y);
    check("model_e_out", longint'($signed(bus.e_out)), m_e);
  end

  task automatic applyReset();
    @(negedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Waits (bounded) for in_ready, presents one sample for exactly one edge.
  task automatic applyStimulus(input int x, input int d, input bit adapt);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_accept", longint'(bus.in_ready), 1);
    #1;
    bus.x_in     = WIDTH'(x);
    bus.d_in     = WIDTH'(d);
    bus.adapt_en = adapt;
    bus.in_valid = 1'b1;
    @(negedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Called right after the accept edge: out_valid must appear at cycle TAPS+2.
  task automatic checkOutput(input string name, input int ey, input int ee);
    int n;
    n = 1;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, bus.out_valid ? longint'(n) : -1, TAPS + 2);
    check({name, "_y"}, longint'($signed(bus.y_out)), ey);
    check({name, "_e"}, longint'($signed(bus.e_out)), ee);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

  initial begin
    int ov_cnt;
    int acc_cnt;
    int acc_pos [2];
    int ov_pos [2];
    rst          = 1'b1;
    bus.x_in     = '0;
    bus.d_in     = '0;
    bus.in_valid = 1'b0;
    bus.adapt_en = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("reset_y", longint'($signed(bus.y_out)), 0);
    check("reset_e", longint'($signed(bus.e_out)), 0);
    check("reset_out_valid", longint'(bus.out_valid), 0);
    check("reset_in_ready", longint'(bus.in_ready), 1);
    #1;
    rst = 1'b0;
    ov_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) ov_cnt++;
    end
    check("idle_no_out_valid", ov_cnt, 0);

    $display("[TB] adapt off, zero weights");
    applyStimulus(64, 32, 1'b0);
    checkOutput("adapt_off_1", 0, 32);
    applyStimulus(64, 32, 1'b0);
    checkOutput("adapt_off_2", 0, 32);

    $display("[TB] adapt on and error saturation");
    applyReset();
    applyStimulus(64, 32, 1'b1);
    checkOutput("adapt_on_1", 0, 32);
    applyStimulus(64, 32, 1'b1);
    checkOutput("adapt_on_2", 32, 0);
    applyStimulus(-128, 127, 1'b1);
    checkOutput("err_sat", -64, 127);

    $display("[TB] cadence with in_valid held");
    applyReset();
    acc_cnt = 0;
    ov_cnt  = 0;
    acc_pos = '{-1, -1};
    ov_pos  = '{-1, -1};
    @(negedge clk);
    #1;
    bus.x_in     = WIDTH'(5);
    bus.d_in     = WIDTH'(3);
    bus.adapt_en = 1'b1;
    bus.in_valid = 1'b1;
    for (int j = 0; j < 20; j++) begin
      if (j > 0) @(negedge clk);
      if (bus.in_ready) begin
        if (acc_cnt < 2) acc_pos[acc_cnt] = j;
        acc_cnt++;
      end
      if (bus.out_valid) begin
        if (ov_cnt < 2) ov_pos[ov_cnt] = j;
        ov_cnt++;
      end
    end
    @(negedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("cadence_accepts", acc_cnt, 2);
    check("cadence_accept0", acc_pos[0], 0);
    check("cadence_accept1", acc_pos[1], 2 * TAPS + 2);
    check("cadence_pulses", ov_cnt, 2);
    check("cadence_pulse0", ov_pos[0], TAPS + 2);
    check("cadence_pulse1", ov_pos[1], 3 * TAPS + 4);
    repeat (12) @(negedge clk);

    $display("[TB] reset during update");
    applyReset();
    applyStimulus(64, 32, 1'b1);
    checkOutput("pre_abort", 0, 32);
    applyStimulus(64, 32, 1'b1);
    repeat (7) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_in_ready", longint'(bus.in_ready), 1);
    check("abort_out_valid", longint'(bus.out_valid), 0);
    @(negedge clk);
    check("abort_y", longint'($signed(bus.y_out)), 0);
    check("abort_e", longint'($signed(bus.e_out)), 0);
    #1;
    rst = 1'b0;
    ov_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid) ov_cnt++;
    end
    check("abort_no_pulse", ov_cnt, 0);
    applyStimulus(64, 32, 1'b0);
    checkOutput("post_abort", 0, 32);

    $display("[TB] weight hold or leakage with adapt off");
    applyReset();
    applyStimulus(64, 64, 1'b1);
    checkOutput("leak_1", 0, 64);
    applyStimulus(0, 0, 1'b0);
    checkOutput("leak_2", 0, 0);
    applyStimulus(127, 0, 1'b0);
`ifdef LMS_LEAK_EN
    checkOutput("leak_3", 126, -126);
`else
    checkOutput("leak_3", 127, -127);
`endif
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
